// File: rtl/apb_reg_bank.sv
// APB4 completer hosting a bank of memory-mapped registers.
// Adds wait states, slave errors, byte strobes, RO hw registers and write pulses.
module apb_reg_bank #(
  parameter int                    ADDR_W      = 32,
  parameter int                    DATA_W      = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_W-1:0]     RESET_VAL   = '0
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int CNT_W = 5;

  localparam logic [ADDR_W-1:0] OFS_MASK =
    ADDR_W'((64'd1 << LSB) - 64'd1);
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  // state_d is the bus phase of the current cycle;
  // state_q remembers it so ACCESS can be told from a missing setup.
  state_e                state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  logic [ADDR_W-1:0]     idx;
  logic [NUM_REGS-1:0]   hit;
  logic                  misalign;
  logic                  range_err;
  logic                  ro_err;
  logic                  err;
  logic                  wr_en;

  // State, counter, registers and pulses; reset wins at any time.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Current phase: ACCESS only after SETUP or an unfinished ACCESS.
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      !psel: begin
        state_d = IDLE;
      end
      psel && !penable: begin
        state_d = SETUP;
      end
      psel && penable: begin
        if (state_q == SETUP) begin
          state_d = ACCESS;
        end else if (state_q == ACCESS && cnt_q <= WAIT_C) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Wait counter: zero in SETUP, counts ACCESS cycles.
  always_comb begin
    cnt_d = '0;
    if (state_d == ACCESS) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Address decode and error classification.
  always_comb begin
    idx = paddr >> LSB;
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (idx == ADDR_W'(i));
    end
    misalign  = (paddr & OFS_MASK) != '0;
    range_err = (hit == '0);
    ro_err    = pwrite && ((hit & RO_MASK) != '0);
    err       = misalign || range_err || ro_err;
  end

  // Completion handshake and read data.
  always_comb begin
    pready  = (state_d == ACCESS) && (cnt_q == WAIT_C);
    pslverr = pready && err;
    wr_en   = pready && pwrite && !err;
    prdata  = '0;
    if (pready && !pwrite && !err) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) begin
          prdata = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W]
                              : regs_q[i];
        end
      end
    end
  end

  // Byte-lane register update and next-cycle write pulse.
  always_comb begin
    wr_pulse_d = wr_en ? hit : '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && hit[i]) begin
        for (int b = 0; b < NB; b++) begin
          if (pstrb[b]) begin
            regs_d[i][8*b +: 8] = pwdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Flattened register view for downstream logic.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: zero-wait bank with RO regs
// and a three-wait-state bank, sharing one APB bus.
module tb_apb_reg_bank;

  logic         pclk = 1'b0;
  logic         preset;
  logic         psel0;
  logic         psel3;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata0;
  logic [31:0]  prdata3;
  logic         pready0;
  logic         pready3;
  logic         pslverr0;
  logic         pslverr3;
  logic [255:0] reg_q0;
  logic [255:0] reg_q3;
  logic [255:0] hw_in0;
  logic [255:0] hw_in3;
  logic [7:0]   wr_pulse0;
  logic [7:0]   wr_pulse3;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [7:0]   pulse_a;
  logic [7:0]   pulse_b;

  always #5 pclk = ~pclk;

  apb_reg_bank #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(8),
    .WAIT_STATES(0), .RO_MASK(8'hC0), .RESET_VAL(32'h0)
  ) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .reg_q(reg_q0),
    .hw_in(hw_in0), .wr_pulse(wr_pulse0)
  );

  apb_reg_bank #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(8),
    .WAIT_STATES(3), .RO_MASK(8'h00), .RESET_VAL(32'h0)
  ) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .reg_q(reg_q3),
    .hw_in(hw_in3), .wr_pulse(wr_pulse3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at #1 after a rising edge; this cycle becomes SETUP.
  task automatic xfer(input bit d3, input logic wr,
                      input logic [31:0] addr,
                      input logic [31:0] data,
                      input logic [3:0] strb, input bit keep,
                      output logic [31:0] rd, output logic er,
                      output int waits, output logic setup_rdy);
    bit done;
    done = 1'b0;
    if (d3) psel3 = 1'b1;
    else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge pclk);
    setup_rdy = d3 ? pready3 : pready0;
    @(posedge pclk);
    #1 penable = 1'b1;
    waits = 0;
    rd = '0;
    er = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge pclk);
      if (d3 ? pready3 : pready0) begin
        done = 1'b1;
        rd = d3 ? prdata3 : prdata0;
        er = d3 ? pslverr3 : pslverr0;
      end else begin
        waits++;
      end
    end
    if (!done) check("pready_timeout", 32'd0, 32'd1);
    @(posedge pclk);
    #1;
    pulse_a = d3 ? wr_pulse3 : wr_pulse0;
    penable = 1'b0;
    if (!keep) begin
      psel0 = 1'b0;
      psel3 = 1'b0;
      @(posedge pclk);
      #1;
      pulse_b = d3 ? wr_pulse3 : wr_pulse0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    logic        sr;

    preset  = 1'b1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    hw_in0  = '1;
    hw_in0[7*32 +: 32] = 32'hCAFE_0001;
    hw_in0[6*32 +: 32] = 32'h1234_5678;
    hw_in3  = '1;

    // 1: reset state, then zero-wait read
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      check("rst_reg0", reg_q0[i*32 +: 32], 32'h0);
      check("rst_reg3", reg_q3[i*32 +: 32], 32'h0);
    end
    check("rst_prdata", prdata0, 32'h0);
    check("rst_pready", {31'd0, pready0}, 32'h0);
    check("rst_pslverr", {31'd0, pslverr0}, 32'h0);
    check("rst_pulse", {24'd0, wr_pulse0}, 32'h0);
    @(posedge pclk);
    #1 preset = 1'b0;

    xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd04_setup_rdy", {31'd0, sr}, 32'd0);
    check("rd04_waits", w, 32'd0);
    check("rd04_data", rd, 32'h0);
    check("rd04_err", {31'd0, er}, 32'd0);

    // 2: full then partial strobe write, back to back
    xfer(0, 1, 32'h08, 32'hDEAD_BEEF, 4'hF, 1, rd, er, w, sr);
    check("wr08a_err", {31'd0, er}, 32'd0);
    check("wr08a_pulse", {24'd0, pulse_a}, 32'h04);
    xfer(0, 1, 32'h08, 32'h1122_3344, 4'b0101, 0, rd, er, w, sr);
    check("wr08b_setup_rdy", {31'd0, sr}, 32'd0);
    check("wr08b_pulse", {24'd0, pulse_a}, 32'h04);
    check("wr08b_pulse_end", {24'd0, pulse_b}, 32'h00);
    check("reg2", reg_q0[2*32 +: 32], 32'hDE22_BE44);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd08_data", rd, 32'hDE22_BE44);
    check("rd08_err", {31'd0, er}, 32'd0);
    xfer(0, 1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, rd, er, w, sr);
    check("wr0c_nostrb_pulse", {24'd0, pulse_a}, 32'h08);
    check("wr0c_nostrb_reg3", reg_q0[3*32 +: 32], 32'h0);

    // 3: RO registers
    xfer(0, 0, 32'h1C, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd1c_data", rd, 32'hCAFE_0001);
    check("rd1c_err", {31'd0, er}, 32'd0);
    xfer(0, 0, 32'h18, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd18_data", rd, 32'h1234_5678);
    xfer(0, 0, 32'h04, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd04_rw_not_hw", rd, 32'h0);
    xfer(0, 1, 32'h1C, 32'h5555_AAAA, 4'hF, 0, rd, er, w, sr);
    check("wr1c_err", {31'd0, er}, 32'd1);
    check("wr1c_pulse", {24'd0, pulse_a}, 32'h00);
    check("wr1c_reg7", reg_q0[7*32 +: 32], 32'h0);

    // 4: out of range and misaligned
    xfer(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd20_err", {31'd0, er}, 32'd1);
    check("rd20_data", rd, 32'h0);
    xfer(0, 1, 32'h20, 32'h1234_0000, 4'hF, 0, rd, er, w, sr);
    check("wr20_err", {31'd0, er}, 32'd1);
    check("wr20_pulse", {24'd0, pulse_a}, 32'h00);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd08_after_bad", rd, 32'hDE22_BE44);
    xfer(0, 0, 32'h05, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("rd05_err", {31'd0, er}, 32'd1);
    check("rd05_data", rd, 32'h0);
    xfer(0, 1, 32'h05, 32'hFFFF_FFFF, 4'hF, 0, rd, er, w, sr);
    check("wr05_err", {31'd0, er}, 32'd1);
    check("wr05_pulse", {24'd0, pulse_a}, 32'h00);
    check("wr05_reg1", reg_q0[1*32 +: 32], 32'h0);

    // missing setup phase is ignored
    psel0   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 32'h10;
    pwdata  = 32'hAAAA_AAAA;
    pstrb   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("nosetup_pready", {31'd0, pready0}, 32'd0);
    end
    @(posedge pclk);
    #1;
    psel0   = 1'b0;
    penable = 1'b0;
    check("nosetup_reg4", reg_q0[4*32 +: 32], 32'h0);
    check("nosetup_pulse", {24'd0, wr_pulse0}, 32'h0);

    // 5: wait states, back-to-back write then read
    xfer(1, 1, 32'h00, 32'hA5A5_0F0F, 4'hF, 1, rd, er, w, sr);
    check("ws_wr_waits", w, 32'd3);
    check("ws_wr_err", {31'd0, er}, 32'd0);
    check("ws_wr_pulse", {24'd0, pulse_a}, 32'h01);
    xfer(1, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("ws_rd_setup_rdy", {31'd0, sr}, 32'd0);
    check("ws_rd_waits", w, 32'd3);
    check("ws_rd_data", rd, 32'hA5A5_0F0F);

    // 6: reset during the ACCESS cycle of a write
    psel0   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h00;
    pwdata  = 32'h55;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1 penable = 1'b1;
    #1 preset = 1'b1;
    @(negedge pclk);
    check("midrst_pready", {31'd0, pready0}, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr0}, 32'd0);
    check("midrst_prdata", prdata0, 32'h0);
    @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("postrst_pready", {31'd0, pready0}, 32'd0);
    check("postrst_reg0", reg_q0[0 +: 32], 32'h0);
    check("postrst_reg2", reg_q0[2*32 +: 32], 32'h0);
    check("postrst_pulse", {24'd0, wr_pulse0}, 32'h0);
    @(posedge pclk);
    #1;
    psel0   = 1'b0;
    penable = 1'b0;
    @(posedge pclk);
    #1;
    xfer(0, 1, 32'h00, 32'h77, 4'hF, 0, rd, er, w, sr);
    check("after_rst_wr_err", {31'd0, er}, 32'd0);
    check("after_rst_pulse", {24'd0, pulse_a}, 32'h01);
    xfer(0, 0, 32'h00, 32'h0, 4'h0, 0, rd, er, w, sr);
    check("after_rst_rd", rd, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
Parametrised APB4 completer that hosts a bank of memory-mapped registers. It is the register-model target for the RAL environment. It extends the plain APB signal set (psel/penable/pwrite/paddr/pwdata/prdata) with pready wait-state insertion, pslverr error signalling, pstrb byte-lane writes, read-only registers fed by hardware, and per-register write pulses to downstream logic.

Parameters:
ADDR_W, 32, paddr width
DATA_W, 32, data width; must be a multiple of 8
NUM_REGS, 8, number of registers; register i sits at byte offset i*(DATA_W/8)
WAIT_STATES, 0, access-phase cycles with pready low before completion (0..15)
RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only (value sourced from hw_in)
RESET_VAL, 0, reset value of every RW register

Ports:
pclk  in  1  clock
preset  in  1  asynchronous, active-high reset
psel  in  1  completer select
penable  in  1  access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  byte address
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  write byte strobes
prdata  out  DATA_W  read data
pready  out  1  transfer completes this cycle
pslverr  out  1  transfer error, valid only when pready=1
reg_q  out  NUM_REGS*DATA_W  current RW register contents, flattened; register i at [i*DATA_W +: DATA_W]
hw_in  in  NUM_REGS*DATA_W  hardware values returned for RO registers
wr_pulse  out  NUM_REGS  one-cycle pulse per register after a successful write

Behaviour:
- Clock and reset: single clock pclk. Reset preset is asynchronous and active-high.
- Reset values:
  - state = IDLE, wait counter = 0.
  - RW registers = RESET_VAL; RO slices of reg_q = 0.
  - prdata = 0, pready = 0, pslverr = 0, wr_pulse = 0.
- FSM states:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- FSM transitions:
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS next cycle when penable=1.
  - ACCESS -> SETUP on the completion cycle if psel=1 & penable=0 follows (back-to-back transfer); otherwise ACCESS -> IDLE.
  - psel & penable seen in IDLE (missing setup) is ignored: no pready, no write.
- Wait counter:
  - Clears on SETUP and increments each ACCESS cycle.
  - pready = (state==ACCESS) & (cnt==WAIT_STATES), combinational from state/counter.
  - WAIT_STATES=0 gives zero-wait completion in the first ACCESS cycle.
- Decode:
  - idx = paddr >> log2(DATA_W/8).
  - Error if paddr low byte-offset bits != 0, or idx >= NUM_REGS.
  - Error if the access is a write to a register with RO_MASK[idx]=1.
- pslverr: equals the error condition during pready=1, else 0.
- Writes (completion cycle, no error):
  - At the clock edge ending the cycle, byte lane b of register idx takes pwdata[8b+:8] where pstrb[b]=1; other lanes hold.
  - pstrb=0 still counts as a write: no data change, wr_pulse still fires.
  - Erroring writes change nothing and produce no wr_pulse.
- wr_pulse[idx]: high exactly one cycle, the cycle after the write commits. Back-to-back writes give consecutive pulses.
- Reads:
  - prdata is driven only while pready=1, else 0.
  - RW register: value = reg_q slice.
  - RO register: value = hw_in slice, sampled in the completion cycle.
  - Erroring read: prdata = 0.
- Signal stability: paddr/pwrite/pwdata/pstrb are held stable by the requester through SETUP and ACCESS; the block samples them only on the completion cycle.
- Reset mid-transfer: the FSM returns to IDLE immediately, any pending write is dropped, and all outputs take their reset values.

Test Plan:
1. Reset with NUM_REGS=8, DATA_W=32, WAIT_STATES=0 -> all reg_q = 0, prdata=0, pready=0, pslverr=0; then read 0x04 -> pready in the first ACCESS cycle, prdata=0x0, pslverr=0.
2. Write 0xDEADBEEF to 0x08 with pstrb=4'hF, then write 0x11223344 to 0x08 with pstrb=4'b0101 -> reg 2 = 0xDE22BE44; wr_pulse[2] high for one cycle after each write; readback returns 0xDE22BE44.
3. RO_MASK=8'hC0, hw_in reg 7 = 0xCAFE0001 -> read 0x1C gives 0xCAFE0001 with pslverr=0; write 0x1C gives pslverr=1, no wr_pulse, reg unchanged.
4. Accesses to 0x20 (idx 8) and 0x05 (misaligned) -> pslverr=1 on the completion cycle, prdata=0, no register change.
5. WAIT_STATES=3 -> pready low for 3 ACCESS cycles and high on the 4th; back-to-back write then read at 0x00 gives SETUP directly after completion and reads the written value.
6. Assert preset during the ACCESS cycle of a write 0x55 to 0x00 -> reg 0 stays 0, pready=0, FSM returns to IDLE; the next transfer completes normally.
